// File: rtl/nexthop_rewrite_stage.sv
// rtl/nexthop_rewrite_stage.sv - IPv4 next-hop lookup and header rewrite on the first two beats
// Optional table read-back port: define NEXTHOP_TBL_READ_EN.
module nexthop_rewrite_stage #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic [31:0]                       mac0_low,
  input  logic [31:0]                       mac0_high,
  input  logic [31:0]                       mac1_low,
  input  logic [31:0]                       mac1_high,
  input  logic [31:0]                       mac2_low,
  input  logic [31:0]                       mac2_high,
  input  logic [31:0]                       mac3_low,
  input  logic [31:0]                       mac3_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
  input  logic                              tbl_wr_req,
  input  logic [2:0]                        tbl_wr_addr,
  input  logic [31:0]                       tbl_wr_ip,
  input  logic [31:0]                       tbl_wr_mac_low,
  input  logic [31:0]                       tbl_wr_mac_high,
  input  logic [7:0]                        tbl_wr_port,
  output logic                              tbl_wr_ack,
`ifdef NEXTHOP_TBL_READ_EN
  input  logic                              tbl_rd_req,
  input  logic [2:0]                        tbl_rd_addr,
  output logic [31:0]                       tbl_rd_ip,
  output logic [7:0]                        tbl_rd_port,
  output logic                              tbl_rd_ack,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]     fwd_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     miss_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_exp_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int CW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {W0, W1, LOOK, OUT0, OUT1, BODY} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] b0_data, b1_data, mod_data;
  logic [KW-1:0] b0_strb, b1_strb;
  logic [UW-1:0] b0_user, b1_user, mod_user;
  logic          b1_last;

  logic [31:0]   tbl_ip   [8];
  logic [47:0]   tbl_mac  [8];
  logic [7:0]    tbl_port [8];
  logic [7:0]    tbl_valid;

  logic [31:0]   dst_ip;
  logic          hit;
  logic [2:0]    hit_idx;
  logic [7:0]    ingress, dst_field, hit_port;
  logic          cpu_bound, is_ipv4, pass_thru, ttl_exp, miss, fwd;
  logic [16:0]   csum_sum;
  logic [15:0]   csum_new;
  logic [47:0]   src_mac;
  logic          unused_bits;

  assign unused_bits = ^{mac0_high[31:16], mac1_high[31:16], mac2_high[31:16],
                         mac3_high[31:16], tbl_wr_mac_high[31:16]};

  assign dst_ip    = {b0_data[15:0], b1_data[255:240]};
  assign ingress   = b0_user[SRC_PORT_POS +: 8];
  assign dst_field = b0_user[DST_PORT_POS +: 8];
  assign cpu_bound = dst_field[1] | dst_field[3] | dst_field[5] | dst_field[7];
  assign is_ipv4   = (b0_data[159:144] == 16'h0800) && (b0_data[143:140] == 4'h4);
  assign pass_thru = cpu_bound || !is_ipv4;
  assign ttl_exp   = !pass_thru && (b0_data[79:72] <= 8'd1);
  assign miss      = !pass_thru && !ttl_exp && !hit;
  assign fwd       = !pass_thru && !ttl_exp && hit;
  assign hit_port  = tbl_port[hit_idx];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (tbl_valid[i] && (tbl_ip[i] == dst_ip)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // TTL drops by one, so the ones-complement checksum rises by 0x0100.
  assign csum_sum = {1'b0, b0_data[63:48]} + 17'h00100;
  assign csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};

  always_comb begin
    src_mac = b0_data[207:160];
    if (hit_port[0])      src_mac = {mac0_high[15:0], mac0_low};
    else if (hit_port[2]) src_mac = {mac1_high[15:0], mac1_low};
    else if (hit_port[4]) src_mac = {mac2_high[15:0], mac2_low};
    else if (hit_port[6]) src_mac = {mac3_high[15:0], mac3_low};
  end

  always_comb begin
    mod_data = b0_data;
    mod_user = b0_user;
    if (fwd) begin
      mod_data[255:208]            = tbl_mac[hit_idx];
      mod_data[207:160]            = src_mac;
      mod_data[79:72]              = b0_data[79:72] - 8'd1;
      mod_data[63:48]              = csum_new;
      mod_user[DST_PORT_POS +: 8]  = hit_port;
    end else if (ttl_exp || miss) begin
      mod_user[DST_PORT_POS +: 8]  = {ingress[6:0], 1'b0};
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) state <= W0;
    else           state <= state_nxt;
  end

  // A single-beat packet lands in the beat-1 slot so OUT1 can emit it directly.
  always_ff @(posedge AXI_ACLK) begin
    case (state)
      W0: if (S_AXIS_TVALID) begin
        if (S_AXIS_TLAST) begin
          b1_data <= S_AXIS_TDATA; b1_strb <= S_AXIS_TSTRB;
          b1_user <= S_AXIS_TUSER; b1_last <= 1'b1;
        end else begin
          b0_data <= S_AXIS_TDATA; b0_strb <= S_AXIS_TSTRB; b0_user <= S_AXIS_TUSER;
        end
      end
      W1: if (S_AXIS_TVALID) begin
        b1_data <= S_AXIS_TDATA; b1_strb <= S_AXIS_TSTRB;
        b1_user <= S_AXIS_TUSER; b1_last <= S_AXIS_TLAST;
      end
      LOOK: begin
        b0_data <= mod_data;
        b0_user <= mod_user;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TDATA  = b0_data;
    M_AXIS_TSTRB  = b0_strb;
    M_AXIS_TUSER  = b0_user;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    case (state)
      W0: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID) state_nxt = S_AXIS_TLAST ? OUT1 : W1;
      end
      W1: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID) state_nxt = LOOK;
      end
      LOOK: state_nxt = OUT0;
      OUT0: begin
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) state_nxt = OUT1;
      end
      OUT1: begin
        M_AXIS_TDATA  = b1_data;
        M_AXIS_TSTRB  = b1_strb;
        M_AXIS_TUSER  = b1_user;
        M_AXIS_TLAST  = b1_last;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) state_nxt = b1_last ? W0 : BODY;
      end
      BODY: begin
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TSTRB  = S_AXIS_TSTRB;
        M_AXIS_TUSER  = S_AXIS_TUSER;
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TLAST  = S_AXIS_TLAST;
        S_AXIS_TREADY = M_AXIS_TREADY;
        if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_nxt = W0;
      end
      default: state_nxt = W0;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      tbl_valid  <= '0;
      tbl_wr_ack <= 1'b0;
    end else begin
      tbl_wr_ack <= tbl_wr_req;
      if (tbl_wr_req) tbl_valid[tbl_wr_addr] <= |tbl_wr_port;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (tbl_wr_req) begin
      tbl_ip[tbl_wr_addr]   <= tbl_wr_ip;
      tbl_mac[tbl_wr_addr]  <= {tbl_wr_mac_high[15:0], tbl_wr_mac_low};
      tbl_port[tbl_wr_addr] <= tbl_wr_port;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET || (reset == CW'(1))) begin
      fwd_count     <= '0;
      miss_count    <= '0;
      ttl_exp_count <= '0;
    end else if (state == LOOK) begin
      if (fwd)     fwd_count     <= fwd_count + CW'(1);
      if (miss)    miss_count    <= miss_count + CW'(1);
      if (ttl_exp) ttl_exp_count <= ttl_exp_count + CW'(1);
    end
  end

`ifdef NEXTHOP_TBL_READ_EN
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) tbl_rd_ack <= 1'b0;
    else           tbl_rd_ack <= tbl_rd_req;
    if (tbl_rd_req) begin
      tbl_rd_ip   <= tbl_ip[tbl_rd_addr];
      tbl_rd_port <= tbl_valid[tbl_rd_addr] ? tbl_port[tbl_rd_addr] : 8'd0;
    end
  end
`endif

endmodule
